// File: rtl/sram_fifo_ctrl.sv
// Streaming FIFO controller around a 1W1R SRAM macro. A 2-entry output buffer
// absorbs the macro's registered read latency so the pop side sustains 1 word/cycle.
module sram_fifo_ctrl #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 31,
    parameter int CNT_WIDTH  = $clog2(DEPTH + 3)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  level,
    output logic                  ram_csb0,
    output logic [ADDR_WIDTH-1:0] ram_addr0,
    output logic [DATA_WIDTH-1:0] ram_din0,
    output logic                  ram_csb1,
    output logic [ADDR_WIDTH-1:0] ram_addr1,
    input  logic [DATA_WIDTH-1:0] ram_dout1
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0]  DEPTH_CNT = CNT_WIDTH'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  ram_cnt_q, ram_cnt_d;
    logic                  rd_inflight_q, rd_inflight_d;
    logic [1:0]            obuf_cnt_q, obuf_cnt_d;
    logic [DATA_WIDTH-1:0] obuf0_q, obuf0_d;
    logic [DATA_WIDTH-1:0] obuf1_q, obuf1_d;
    logic [CNT_WIDTH-1:0]  level_q, level_d;
    logic                  out_valid_q, out_valid_d;

    logic       push_s;
    logic       pop_s;
    logic       issue_s;
    logic [2:0] pend_s;
    logic [1:0] slot_s;

    // Pointers wrap at DEPTH-1, which need not be a power of two.
    function automatic logic [ADDR_WIDTH-1:0] ptr_next(input logic [ADDR_WIDTH-1:0] p);
        return (p == LAST_ADDR) ? {ADDR_WIDTH{1'b0}} : p + ADDR_WIDTH'(1);
    endfunction

    // Handshake and read-issue decisions; flush and reset suppress both macro ports.
    always_comb begin
        in_ready = rst_n && !flush && (ram_cnt_q < DEPTH_CNT);
        push_s   = in_valid && in_ready;
        pop_s    = (obuf_cnt_q != 2'd0) && out_ready && !flush;
        pend_s   = {1'b0, obuf_cnt_q} + {2'b00, rd_inflight_q} - {2'b00, pop_s};
        issue_s  = rst_n && !flush && (ram_cnt_q != {CNT_WIDTH{1'b0}}) && (pend_s < 3'd2);
        slot_s   = obuf_cnt_q - {1'b0, pop_s};
    end

    assign ram_csb0  = !push_s;
    assign ram_addr0 = wr_ptr_q;
    assign ram_din0  = in_data;
    assign ram_csb1  = !issue_s;
    assign ram_addr1 = rd_ptr_q;

    assign out_valid = out_valid_q;
    assign out_data  = obuf0_q;
    assign level     = level_q;

    // Next-state for pointers, SRAM occupancy and the output buffer.
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        ram_cnt_d     = ram_cnt_q;
        rd_inflight_d = 1'b0;
        obuf_cnt_d    = obuf_cnt_q;
        obuf0_d       = obuf0_q;
        obuf1_d       = obuf1_q;
        if (flush) begin
            wr_ptr_d   = {ADDR_WIDTH{1'b0}};
            rd_ptr_d   = {ADDR_WIDTH{1'b0}};
            ram_cnt_d  = {CNT_WIDTH{1'b0}};
            obuf_cnt_d = 2'd0;
            obuf0_d    = {DATA_WIDTH{1'b0}};
            obuf1_d    = {DATA_WIDTH{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = ptr_next(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (issue_s) begin
                rd_ptr_d = ptr_next(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, issue_s})
                2'b10:   ram_cnt_d = ram_cnt_q + CNT_WIDTH'(1);
                2'b01:   ram_cnt_d = ram_cnt_q - CNT_WIDTH'(1);
                default: ram_cnt_d = ram_cnt_q;
            endcase
            rd_inflight_d = issue_s;
            if (pop_s) begin
                obuf0_d = obuf1_q;
            end else begin
                obuf0_d = obuf0_q;
            end
            // Read data is only valid at this edge, so it lands straight in the free slot.
            if (rd_inflight_q) begin
                if (slot_s == 2'd0) begin
                    obuf0_d = ram_dout1;
                end else begin
                    obuf1_d = ram_dout1;
                end
            end else begin
                obuf1_d = obuf1_q;
            end
            obuf_cnt_d = obuf_cnt_q + {1'b0, rd_inflight_q} - {1'b0, pop_s};
        end
        out_valid_d = (obuf_cnt_d != 2'd0);
        level_d     = ram_cnt_d + CNT_WIDTH'(rd_inflight_d) + CNT_WIDTH'(obuf_cnt_d);
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= {ADDR_WIDTH{1'b0}};
            rd_ptr_q      <= {ADDR_WIDTH{1'b0}};
            ram_cnt_q     <= {CNT_WIDTH{1'b0}};
            rd_inflight_q <= 1'b0;
            obuf_cnt_q    <= 2'd0;
            obuf0_q       <= {DATA_WIDTH{1'b0}};
            obuf1_q       <= {DATA_WIDTH{1'b0}};
            level_q       <= {CNT_WIDTH{1'b0}};
            out_valid_q   <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            ram_cnt_q     <= ram_cnt_d;
            rd_inflight_q <= rd_inflight_d;
            obuf_cnt_q    <= obuf_cnt_d;
            obuf0_q       <= obuf0_d;
            obuf1_q       <= obuf1_d;
            level_q       <= level_d;
            out_valid_q   <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed bench for sram_fifo_ctrl with a behavioural 1W1R macro whose read data
// is valid only between a short delay after the latching edge and the next edge.
module tb_sram_fifo_ctrl;

    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0] in_data, out_data, ram_din0, ram_dout1;
    logic [5:0]    level;
    logic          ram_csb0, ram_csb1;
    logic [4:0]    ram_addr0, ram_addr1;

    logic [DW-1:0] mem [0:31];
    logic          rd_en_l = 1'b0;
    logic [4:0]    rd_addr_l = 5'd0;

    int total = 0;
    int bad   = 0;

    sram_fifo_ctrl dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level),
        .ram_csb0(ram_csb0), .ram_addr0(ram_addr0), .ram_din0(ram_din0),
        .ram_csb1(ram_csb1), .ram_addr1(ram_addr1), .ram_dout1(ram_dout1)
    );

    always #5 clk = ~clk;

    // Macro model: garbage right after each edge, read data 2ns later.
    always @(posedge clk) begin
        rd_en_l   = !ram_csb1;
        rd_addr_l = ram_addr1;
        if (!ram_csb0) mem[ram_addr0] = ram_din0;
        ram_dout1 <= {4{32'hDEAD_BEEF}};
        #2;
        if (rd_en_l) ram_dout1 <= mem[rd_addr_l];
    end

    function automatic logic [DW-1:0] pat(input int v);
        return {4{v}};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (2) tick;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%0b want=0", in_ready); end
        total++; if (ram_csb0 !== 1'b1) begin bad++; $display("FAIL reset_csb0 got=%0b want=1", ram_csb0); end
        total++; if (ram_csb1 !== 1'b1) begin bad++; $display("FAIL reset_csb1 got=%0b want=1", ram_csb1); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
        total++; if (level !== 6'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
        total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
        rst_n = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%0b want=1", in_ready); end
        tick;
    endtask

    task automatic test_single;
        logic [DW-1:0] a5;
        a5 = {16{8'hA5}};
        in_valid = 1'b1; in_data = a5; out_ready = 1'b0;
        #1;
        total++; if (ram_csb0 !== 1'b0 || ram_addr0 !== 5'd0 || ram_din0 !== a5) begin
            bad++; $display("FAIL single_write csb0=%0b addr0=%0d want csb0=0 addr0=0", ram_csb0, ram_addr0); end
        tick;
        in_valid = 1'b0;
        #1;
        total++; if (ram_csb1 !== 1'b0 || ram_addr1 !== 5'd0) begin
            bad++; $display("FAIL single_issue csb1=%0b addr1=%0d want 0 0", ram_csb1, ram_addr1); end
        total++; if (out_valid !== 1'b0 || level !== 6'd1) begin
            bad++; $display("FAIL single_e0 out_valid=%0b level=%0d want 0 1", out_valid, level); end
        tick;
        total++; if (out_valid !== 1'b0 || level !== 6'd1 || ram_csb1 !== 1'b1) begin
            bad++; $display("FAIL single_e1 out_valid=%0b level=%0d csb1=%0b want 0 1 1", out_valid, level, ram_csb1); end
        tick;
        total++; if (out_valid !== 1'b1 || out_data !== a5 || level !== 6'd1) begin
            bad++; $display("FAIL single_e2 out_valid=%0b data=%h level=%0d want 1 a5.. 1", out_valid, out_data, level); end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0 || level !== 6'd0) begin
            bad++; $display("FAIL single_pop out_valid=%0b level=%0d want 0 0", out_valid, level); end
    endtask

    task automatic test_fill;
        int acc = 0;
        int got = 0;
        out_ready = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 45; c++) begin
            in_data = pat(acc);
            #1;
            if (in_ready) acc++;
            tick;
        end
        in_valid = 1'b0;
        #1;
        total++; if (acc != 33) begin bad++; $display("FAIL fill_accepts got=%0d want=33", acc); end
        total++; if (level !== 6'd33) begin bad++; $display("FAIL fill_level got=%0d want=33", level); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_in_ready got=%0b want=0", in_ready); end
        out_ready = 1'b1;
        for (int c = 0; c < 80 && got < 33; c++) begin
            #1;
            if (out_valid) begin
                total++; if (out_data !== pat(got)) begin bad++; $display("FAIL fill_drain idx=%0d got=%h want=%h", got, out_data, pat(got)); end
                got++;
            end
            tick;
        end
        out_ready = 1'b0;
        tick;
        total++; if (got != 33 || level !== 6'd0) begin bad++; $display("FAIL fill_end pops=%0d level=%0d want 33 0", got, level); end
    endtask

    task automatic test_back_to_back;
        int pushed = 0;
        int popped = 0;
        int wraps = 0;
        int prev = -1;
        bit primed = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 300 && popped < 100; c++) begin
            in_valid = (pushed < 100);
            in_data  = pat(1000 + pushed);
            #1;
            if (primed && pushed < 100) begin
                total++; if (out_valid !== 1'b1 || level < 6'd2 || level > 6'd3) begin
                    bad++; $display("FAIL stream_steady out_valid=%0b level=%0d want 1 and 2..3", out_valid, level); end
            end
            if (out_valid) begin
                total++; if (out_data !== pat(1000 + popped)) begin bad++; $display("FAIL stream_order idx=%0d got=%h want=%h", popped, out_data, pat(1000 + popped)); end
                popped++;
                primed = 1'b1;
            end
            if (in_valid && in_ready) begin
                if (prev == 30 && ram_addr0 == 5'd0) wraps++;
                total++; if (ram_addr0 > 5'd30) begin bad++; $display("FAIL stream_addr got=%0d want<=30", ram_addr0); end
                prev = int'(ram_addr0);
                pushed++;
            end
            tick;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        total++; if (popped != 100) begin bad++; $display("FAIL stream_count got=%0d want=100", popped); end
        total++; if (wraps < 3) begin bad++; $display("FAIL stream_wraps got=%0d want>=3", wraps); end
    endtask

    task automatic test_random_ready;
        int pushed = 0;
        int popped = 0;
        for (int c = 0; c < 4000 && popped < 500; c++) begin
            in_valid  = (pushed < 500);
            in_data   = pat(5000 + pushed);
            out_ready = 1'($urandom_range(0, 1));
            #1;
            total++; if (int'(level) != pushed - popped) begin bad++; $display("FAIL random_level got=%0d want=%0d", level, pushed - popped); end
            if (out_valid && out_ready) begin
                total++; if (out_data !== pat(5000 + popped)) begin bad++; $display("FAIL random_order idx=%0d got=%h want=%h", popped, out_data, pat(5000 + popped)); end
                popped++;
            end
            if (in_valid && in_ready) pushed++;
            tick;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        total++; if (popped != 500 || level !== 6'd0) begin bad++; $display("FAIL random_end pops=%0d level=%0d want 500 0", popped, level); end
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        for (int i = 0; i < 11; i++) begin
            in_valid = 1'b1; in_data = pat(7000 + i);
            tick;
        end
        in_valid = 1'b0;
        repeat (3) tick;
        total++; if (level !== 6'd11) begin bad++; $display("FAIL flush_prefill got=%0d want=11", level); end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        total++; if (level !== 6'd10) begin bad++; $display("FAIL flush_level10 got=%0d want=10", level); end
        flush = 1'b1; in_valid = 1'b1; in_data = pat(32'h9999); out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0 || ram_csb0 !== 1'b1 || ram_csb1 !== 1'b1) begin
            bad++; $display("FAIL flush_cycle in_ready=%0b csb0=%0b csb1=%0b want 0 1 1", in_ready, ram_csb0, ram_csb1); end
        tick;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        total++; if (level !== 6'd0 || out_valid !== 1'b0 || out_data !== '0) begin
            bad++; $display("FAIL flush_after level=%0d out_valid=%0b data=%h want 0 0 0", level, out_valid, out_data); end
        in_valid = 1'b1; in_data = DW'(32'h1234);
        #1;
        total++; if (ram_csb0 !== 1'b0 || ram_addr0 !== 5'd0) begin
            bad++; $display("FAIL flush_push csb0=%0b addr0=%0d want 0 0", ram_csb0, ram_addr0); end
        tick;
        in_valid = 1'b0;
        for (int c = 0; c < 10 && !out_valid; c++) tick;
        total++; if (out_valid !== 1'b1 || out_data !== DW'(32'h1234)) begin
            bad++; $display("FAIL flush_next out_valid=%0b data=%h want 1 1234", out_valid, out_data); end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        total++; if (level !== 6'd0) begin bad++; $display("FAIL flush_drain level=%0d want=0", level); end
    endtask

    task automatic test_async_reset;
        logic [DW-1:0] w;
        w = pat(32'hBEEF);
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = pat(8000 + i);
            tick;
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total++; if (ram_csb0 !== 1'b1 || ram_csb1 !== 1'b1 || in_ready !== 1'b0) begin
            bad++; $display("FAIL arst_comb csb0=%0b csb1=%0b in_ready=%0b want 1 1 0", ram_csb0, ram_csb1, in_ready); end
        total++; if (out_valid !== 1'b0 || level !== 6'd0) begin
            bad++; $display("FAIL arst_state out_valid=%0b level=%0d want 0 0", out_valid, level); end
        tick;
        tick;
        rst_n = 1'b1; in_valid = 1'b1; in_data = w; out_ready = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1 || ram_csb0 !== 1'b0 || ram_addr0 !== 5'd0) begin
            bad++; $display("FAIL arst_resume in_ready=%0b csb0=%0b addr0=%0d want 1 0 0", in_ready, ram_csb0, ram_addr0); end
        tick;
        in_valid = 1'b0;
        #1;
        total++; if (ram_csb1 !== 1'b0 || ram_addr1 !== 5'd0) begin
            bad++; $display("FAIL arst_issue csb1=%0b addr1=%0d want 0 0", ram_csb1, ram_addr1); end
        tick;
        tick;
        total++; if (out_valid !== 1'b1 || out_data !== w) begin
            bad++; $display("FAIL arst_data out_valid=%0b data=%h want 1 %h", out_valid, out_data, w); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_random_ready();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
